noc_traffic_injector: RTL and testbench

- Synthesizable packet source that drives one local injection port of the NoC. It feeds the router input exactly as the destination-side sink consumes it: valid/ready/data plus credit return.
- Generates NUM_PKTS packets of PKT_LEN flits each, addressed to DST_ID, with deterministic, checkable payloads.
- Transmits only while it holds credits. Credits are returned by downstream credit_upd pulses.

---
 rtl/noc_traffic_injector.sv | 92 +++++++++
 tb/tb_noc_traffic_injector.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/noc_traffic_injector.sv
// noc_traffic_injector: credit-based NoC packet source; define NOC_INJ_RANDGAP_EN for LFSR-driven inter-packet gaps.
module noc_traffic_injector #(
  parameter int DW = 32,
  parameter int CREDITS = 4,
  parameter int PKT_LEN = 4,
  parameter int NUM_PKTS = 250,
  parameter int GAP = 2,
  parameter logic [7:0] SRC_ID = 8'd0,
  parameter logic [7:0] DST_ID = 8'd1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  output logic          valid,
  input  logic          ready,
  output logic [DW-1:0] data,
  input  logic          credit_upd,
  output logic          done,
  output logic [31:0]   flit_cnt,
  output logic          cred_err
);
  localparam int CW = $clog2(CREDITS + 1);
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] credit_cnt;
  logic [15:0] pkt_seq, gap_cnt, gap_len;
  logic [7:0] flit_idx;
  logic [1:0] typ;
  logic xfer, last;
  assign valid = (state == S_SEND) && (credit_cnt != '0);
  assign xfer = valid && ready;
  assign last = flit_idx == 8'(PKT_LEN - 1);
  assign done = state == S_DONE;
  assign typ = (PKT_LEN == 1) ? 2'b11 : (flit_idx == 8'd0) ? 2'b01 : last ? 2'b10 : 2'b00;
`ifdef NOC_INJ_RANDGAP_EN
  logic [15:0] lfsr, lfsr_nxt;
  assign lfsr_nxt = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  assign gap_len = {12'd0, lfsr_nxt[3:0]};
  always_ff @(posedge clk)
    if (!rstn) lfsr <= 16'hACE1;
    else if (xfer && last) lfsr <= lfsr_nxt;
`else
  assign gap_len = 16'(GAP);
`endif
  always_comb begin
    data = '0;
    data[DW-1:DW-2] = typ;
    if (flit_idx == 8'd0) begin
      data[DW-3:DW-10] = DST_ID;
      data[DW-11:DW-18] = data[DW-11:DW-18] | SRC_ID;
      data[15:0] = data[15:0] | pkt_seq;
    end else begin
      data[23:8] = pkt_seq;
      data[7:0] = flit_idx;
    end
  end
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: state_nxt = start ? S_SEND : S_IDLE;
      S_SEND: if (xfer && last)
        state_nxt = (pkt_seq == 16'(NUM_PKTS - 1)) ? S_DONE : (gap_len == '0) ? S_SEND : S_GAP;
      S_GAP: state_nxt = (gap_cnt == '0) ? S_SEND : S_GAP;
      default: state_nxt = S_DONE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= S_IDLE;
      credit_cnt <= CW'(CREDITS);
      pkt_seq <= '0;
      flit_idx <= '0;
      gap_cnt <= '0;
      flit_cnt <= '0;
      cred_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (xfer && !credit_upd) credit_cnt <= credit_cnt - 1'b1;
      else if (!xfer && credit_upd) begin
        if (credit_cnt == CW'(CREDITS)) cred_err <= 1'b1;
        else credit_cnt <= credit_cnt + 1'b1;
      end
      if (xfer) begin
        flit_cnt <= flit_cnt + 1;
        flit_idx <= last ? 8'd0 : flit_idx + 8'd1;
        if (last) pkt_seq <= pkt_seq + 16'd1;
        if (last && gap_len != '0) gap_cnt <= gap_len - 16'd1;
      end
      if (state == S_GAP && gap_cnt != '0) gap_cnt <= gap_cnt - 16'd1;
    end
  end
endmodule

// File: tb/tb_noc_traffic_injector.sv
// tb_noc_traffic_injector: vector table plus flit scoreboard for noc_traffic_injector.
module tb_noc_traffic_injector;
  localparam int DST = 1, SRC = 0, NP = 250, PL = 4;
  logic clk = 0, rstn = 0, start = 0, ready = 0, credit_upd = 0, auto_cred = 0;
  logic valid, done, cred_err;
  logic [31:0] data, flit_cnt;
  logic start2 = 0, ready2 = 1, credit_upd2;
  logic valid2, done2, cred_err2;
  logic [31:0] data2, flit_cnt2;
  int n_vec = 0, n_bad = 0;
  logic [31:0] exp_q[$];

  noc_traffic_injector u_dut (
    .clk(clk), .rstn(rstn), .start(start), .valid(valid), .ready(ready), .data(data),
    .credit_upd(credit_upd), .done(done), .flit_cnt(flit_cnt), .cred_err(cred_err));

  noc_traffic_injector #(.GAP(3), .PKT_LEN(1), .NUM_PKTS(3)) u_dut2 (
    .clk(clk), .rstn(rstn), .start(start2), .valid(valid2), .ready(ready2), .data(data2),
    .credit_upd(credit_upd2), .done(done2), .flit_cnt(flit_cnt2), .cred_err(cred_err2));

  assign credit_upd2 = valid2 & ready2;
  always #5 clk = ~clk;

  typedef struct {
    logic st, rdy, cu;
    logic ev;
    int cnt;
    logic err;
  } vec_t;
  vec_t tbl[27];

  function automatic logic [31:0] model_flit(int plen, int seq, int idx);
    logic [1:0] t;
    t = (plen == 1) ? 2'b11 : (idx == 0) ? 2'b01 : (idx == plen - 1) ? 2'b10 : 2'b00;
    if (idx == 0) return {t, 30'd0} | (32'(DST) << 22) | (32'(SRC) << 14) | 32'(seq);
    return {t, 30'd0} | (32'(seq) << 8) | 32'(idx);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_stream();
    for (int p = 0; p < NP; p++)
      for (int i = 0; i < PL; i++) exp_q.push_back(model_flit(PL, p, i));
  endtask

  task automatic tick();
    logic x;
    x = valid && ready && rstn;
    if (x) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL extra_flit: got %h with nothing expected", data);
      end else check("flit", data, exp_q.pop_front());
    end
    @(posedge clk);
    #1;
    if (auto_cred) credit_upd = x;
  endtask

  task automatic check_reset(string tag);
    check({tag, "_valid"}, 32'(valid), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_flit_cnt"}, flit_cnt, 0);
    check({tag, "_cred_err"}, 32'(cred_err), 0);
  endtask

  initial begin
    int seq2;
    tbl = '{
      '{1,1,0, 1, 0,0}, '{1,1,0, 1, 1,0}, '{1,1,0, 1, 2,0}, '{1,1,0, 1, 3,0},
      '{1,1,0, 0, 4,0}, '{1,1,0, 0, 4,0}, '{1,1,0, 0, 4,0}, '{1,1,0, 0, 4,0},
      '{1,1,1, 1, 4,0}, '{1,0,0, 1, 4,0}, '{1,1,0, 0, 5,0}, '{1,1,0, 0, 5,0},
      '{1,1,1, 1, 5,0}, '{1,0,1, 1, 5,0}, '{1,1,1, 1, 6,0}, '{1,1,1, 1, 7,0},
      '{1,0,1, 1, 7,0}, '{1,0,1, 1, 7,0}, '{1,0,1, 1, 7,1}, '{1,0,0, 1, 7,1},
      '{1,1,0, 0, 8,1}, '{1,1,0, 0, 8,1}, '{1,1,0, 1, 8,1}, '{1,1,0, 1, 9,1},
      '{1,1,0, 1,10,1}, '{1,1,0, 0,11,1}, '{1,1,0, 0,11,1}};
    tick();
    tick();
    check_reset("rst");
    check("rst_valid2", 32'(valid2), 0);
    rstn = 1;
    tick();
    // single-flit packets with GAP=3: valid on cycles 1, 5, 9
    start2 = 1;
    seq2 = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      check($sformatf("gap_valid_c%0d", c), 32'(valid2), 32'(c == 1 || c == 5 || c == 9));
      if (valid2) check("single_flit", data2, model_flit(1, seq2++, 0));
    end
    check("gap_done", 32'(done2), 1);
    check("gap_flit_cnt", flit_cnt2, 3);
    push_stream();
    for (int r = 0; r < 27; r++) begin
      start = tbl[r].st;
      ready = tbl[r].rdy;
      credit_upd = tbl[r].cu;
      tick();
      check($sformatf("tbl%0d_valid", r), 32'(valid), 32'(tbl[r].ev));
      check($sformatf("tbl%0d_flit_cnt", r), flit_cnt, 32'(tbl[r].cnt));
      check($sformatf("tbl%0d_cred_err", r), 32'(cred_err), 32'(tbl[r].err));
    end
    rstn = 0;
    start = 0;
    credit_upd = 0;
    tick();
    exp_q.delete();
    check_reset("rst2");
    rstn = 1;
    tick();
    start = 1;
    push_stream();
    auto_cred = 1;
    for (int c = 0; c < 2000 && flit_cnt != 22; c++) tick();
    check("reach_pkt5_flit2", flit_cnt, 22);
    rstn = 0;
    tick();
    exp_q.delete();
    check_reset("midpkt_rst");
    push_stream();
    rstn = 1;
    for (int c = 0; c < 5000 && !done; c++) tick();
    check("run_done", 32'(done), 1);
    check("run_flit_cnt", flit_cnt, 1000);
    check("run_queue_left", exp_q.size(), 0);
    check("run_cred_err", 32'(cred_err), 0);
    for (int c = 0; c < 6; c++) begin
      tick();
      check("post_done_valid", 32'(valid), 0);
      check("post_done_held", 32'(done), 1);
    end
    check("post_done_cnt", flit_cnt, 1000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
